// File: rtl/uart_tx.sv
// Purpose: UART transmitter; valid/ready word in, framed serial out (start, LSB-first data, optional even parity, 1-2 stop bits).
// Latency: accept at edge N drives the start bit from cycle N+1; a frame lasts (1+BIT+PARITY_EN+STOP_BIT)*CLKS_PER_BIT cycles.
// Backpressure: tx_ready is low for the whole frame and rises for one idle cycle before the next word can be taken.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BIT          = 8,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BIT     = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [BIT-1:0] tx_data,
    input  logic           tx_valid,
    output logic           tx_ready,
    output logic           tx,
    output logic           tx_busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(BIT + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(BIT - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    // Counts data bits in DATA and stop-bit periods in STOP; zeroed on entry to either.
    logic [IW-1:0]   idx_q, idx_d;
    logic [BIT-1:0]  shift_q, shift_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            baud_last;

    // Next-state, counters and datapath; outputs are decoded from the next state so they can be registered.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        baud_last = (baud_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                // tx_ready is high throughout IDLE, so tx_valid alone marks the accept edge.
                if (tx_valid) begin
                    shift_d = tx_data;
                    par_d   = ^tx_data;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == BIT_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                // The baud counter wraps between stop-bit periods without a state change.
                if (baud_last) begin
                    baud_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                baud_d  = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any partial frame and idles the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign tx_ready = ~busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Purpose: directed checks of uart_tx in three configurations sharing one stimulus stream.
// Latency: each frame is checked cycle by cycle against hand-written line levels.
// Backpressure: tx_valid is held across busy periods to exercise the ready handshake.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [2:0] tx_w, rdy_w, busy_w;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cnt;
    bit cnt_en = 1'b0;

    always #5 clk = ~clk;

    // 0: base config, 1: even parity, 2: two stop bits
    uart_tx #(.CLKS_PER_BIT(4), .BIT(8), .PARITY_EN(0), .STOP_BIT(1)) u_base (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]));
    uart_tx #(.CLKS_PER_BIT(4), .BIT(8), .PARITY_EN(1), .STOP_BIT(1)) u_par (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]));
    uart_tx #(.CLKS_PER_BIT(4), .BIT(8), .PARITY_EN(0), .STOP_BIT(2)) u_stop2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]));

    // Accepts seen by the two-stop-bit instance while counting is enabled.
    always @(posedge clk) begin
        if (!cnt_en)
            acc_cnt <= 0;
        else if (tx_valid && rdy_w[2])
            acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Called at the negedge of the first start-bit cycle; lv lists line levels, one char per bit period.
    task automatic expect_frame(input int s, input string lv, input string tag, input bit fin);
        for (int i = 0; i < lv.len(); i++) begin
            for (int c = 0; c < 4; c++) begin
                chk({tag, "_tx"}, 32'(tx_w[s]), (lv[i] == 8'h31) ? 32'd1 : 32'd0);
                chk({tag, "_rdy"}, 32'(rdy_w[s]), 32'd0);
                @(negedge clk);
            end
        end
        if (fin) begin
            chk({tag, "_end_tx"}, 32'(tx_w[s]), 32'd1);
            chk({tag, "_end_rdy"}, 32'(rdy_w[s]), 32'd1);
            chk({tag, "_end_busy"}, 32'(busy_w[s]), 32'd0);
        end
    endtask

    // One-cycle valid pulse; returns at the negedge of the first start-bit cycle.
    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic expect_idle(input int s, input int n, input string tag);
        int lows = 0;
        for (int i = 0; i < n; i++) begin
            if (tx_w[s] !== 1'b1) lows++;
            @(negedge clk);
        end
        chk(tag, 32'(lows), 32'd0);
    endtask

    initial begin
        int gap;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'hFF;

        // Reset held: valid toggling must not disturb the idle outputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx_w[0]), 32'd1);
            chk("rst_rdy", 32'(rdy_w[0]), 32'd1);
            chk("rst_busy", 32'(busy_w[0]), 32'd0);
            tx_valid = i[0];
        end
        @(negedge clk);
        tx_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_tx", 32'(tx_w[0]), 32'd1);
            chk("post_rst_rdy", 32'(rdy_w[0]), 32'd1);
        end

        // Single frame 0xA5.
        send(8'hA5);
        expect_frame(0, "0101001011", "a5", 1'b1);
        expect_idle(0, 6, "a5_idle");

        // Even parity: 0x01 -> parity 1, 0xA5 -> parity 0.
        send(8'h01);
        expect_frame(1, "01000000011", "par01", 1'b1);
        expect_idle(1, 4, "par01_idle");
        send(8'hA5);
        expect_frame(1, "01010010101", "para5", 1'b1);
        expect_idle(1, 4, "para5_idle");

        // Back-to-back on the two-stop-bit instance.
        cnt_en   = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hFF;
        expect_frame(2, "000000000", "b2b0", 1'b0);
        gap = 0;
        while (tx_w[2] === 1'b1 && gap < 50) begin
            gap++;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        chk("b2b_gap", 32'(gap), 32'd9);
        expect_frame(2, "01111111111", "b2bff", 1'b1);
        expect_idle(2, 20, "b2b_idle");
        chk("b2b_accepts", 32'(acc_cnt), 32'd2);
        cnt_en = 1'b0;
        repeat (40) @(negedge clk);

        // Ignored input: data change and valid assertion mid-frame.
        send(8'hA5);
        expect_frame(0, "01010", "ign_a", 1'b0);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        expect_frame(0, "01011", "ign_b", 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        expect_frame(0, "0001111001", "ign_3c", 1'b1);
        expect_idle(0, 20, "ign_idle");

        // Reset during data bit 3 of 0xA5.
        send(8'hA5);
        expect_frame(0, "0101", "rmid", 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rmid_async_tx", 32'(tx_w[0]), 32'd1);
        chk("rmid_async_rdy", 32'(rdy_w[0]), 32'd1);
        chk("rmid_async_busy", 32'(busy_w[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_idle(0, 6, "rmid_idle");
        send(8'h5A);
        expect_frame(0, "0010110101", "r5a", 1'b1);
        expect_idle(0, 6, "r5a_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
